vtage_update_ctrl: RTL and testbench

- Update/allocation controller directly upstream of vtage_bank's feedback and update ports.
- Accepts per-lane commit records: the prediction the bank produced plus the architecturally correct value.
- Buffers records in a bundle FIFO and probes the bank's fb_* port for tag match and allocation availability.
- Drives one-cycle ud_* command pulses that train confidence, usefulness, tag and value fields.

---
 rtl/vtage_update_ctrl.sv | 233 +++++++++++++++++++++++
 tb/tb_vtage_update_ctrl.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vtage_update_ctrl.sv
// VTAGE update controller: buffers commit bundles, probes the bank, then issues one-cycle ud_* commands.
// Latency 3 cycles from push into an idle/empty queue to ud pulses; 1 bundle per 2 cycles; cm_ready_o drops only when the FIFO is full.
module vtage_update_ctrl #(
  parameter  int P_NUM_PRED     = 2,
  parameter  int P_NUM_ENTRIES  = 256,
  parameter  int P_TAG_WIDTH    = 8,
  parameter  int P_CONF_WIDTH   = 8,
  parameter  int P_FIFO_DEPTH   = 4,
  parameter  int P_STAT_WIDTH   = 16,
  localparam int LP_INDEX_WIDTH = $clog2(P_NUM_ENTRIES)
) (
  input  logic                                          clk_i,
  input  logic                                          rst_i,
  input  logic                                          cm_valid_i,
  output logic                                          cm_ready_o,
  input  logic [P_NUM_PRED-1:0]                         cm_lane_valid_i,
  input  logic [P_NUM_PRED-1:0][LP_INDEX_WIDTH-1:0]     cm_index_i,
  input  logic [P_NUM_PRED-1:0][P_TAG_WIDTH-1:0]        cm_tag_i,
  input  logic [P_NUM_PRED-1:0]                         cm_hit_i,
  input  logic [P_NUM_PRED-1:0][P_CONF_WIDTH-1:0]       cm_conf_i,
  input  logic [P_NUM_PRED-1:0][LP_INDEX_WIDTH-1:0]     cm_pred_value_i,
  input  logic [P_NUM_PRED-1:0][LP_INDEX_WIDTH-1:0]     cm_actual_value_i,
  input  logic                                          flush_i,
  output logic [P_NUM_PRED-1:0][LP_INDEX_WIDTH-1:0]     fb_index_o,
  output logic [P_NUM_PRED-1:0][P_TAG_WIDTH-1:0]        fb_tag_o,
  input  logic [P_NUM_PRED-1:0]                         fb_tag_match_i,
  input  logic [P_NUM_PRED-1:0]                         fb_alloc_avail_i,
  output logic [P_NUM_PRED-1:0][LP_INDEX_WIDTH-1:0]     ud_index_o,
  output logic [P_NUM_PRED-1:0]                         ud_incr_conf_o,
  output logic [P_NUM_PRED-1:0]                         ud_rst_conf_o,
  output logic [P_NUM_PRED-1:0]                         ud_incr_use_o,
  output logic [P_NUM_PRED-1:0]                         ud_decr_use_o,
  output logic [P_NUM_PRED-1:0]                         ud_rst_use_o,
  output logic [P_NUM_PRED-1:0]                         ud_load_tag_o,
  output logic [P_NUM_PRED-1:0]                         ud_load_value_o,
  output logic [P_NUM_PRED-1:0][P_TAG_WIDTH-1:0]        ud_tag_o,
  output logic [P_NUM_PRED-1:0][LP_INDEX_WIDTH-1:0]     ud_value_o,
  output logic                                          busy_o,
  output logic [P_STAT_WIDTH-1:0]                       stat_alloc_fail_o,
  output logic [P_STAT_WIDTH-1:0]                       stat_drop_o
);

  localparam int LP_PTR_W = $clog2(P_FIFO_DEPTH);
  localparam int LP_CNT_W = LP_PTR_W + 1;

  // act holds lane_valid in the FIFO and lane_valid & ~dropped once latched
  typedef struct packed {
    logic [P_NUM_PRED-1:0]                     act;
    logic [P_NUM_PRED-1:0][LP_INDEX_WIDTH-1:0] index;
    logic [P_NUM_PRED-1:0][P_TAG_WIDTH-1:0]    tag;
    logic [P_NUM_PRED-1:0]                     hit;
    logic [P_NUM_PRED-1:0][P_CONF_WIDTH-1:0]   conf;
    logic [P_NUM_PRED-1:0][LP_INDEX_WIDTH-1:0] pred;
    logic [P_NUM_PRED-1:0][LP_INDEX_WIDTH-1:0] actual;
  } bundle_t;

  typedef enum logic [1:0] {S_IDLE, S_LOOKUP, S_UPDATE} state_t;

  state_t                  r_state, w_state_nxt;
  bundle_t                 r_mem [P_FIFO_DEPTH];
  bundle_t                 r_work, w_push_bnd, w_head;
  logic [LP_PTR_W-1:0]     r_wr_ptr, r_rd_ptr;
  logic [LP_CNT_W-1:0]     r_count;
  logic                    w_full, w_empty, w_push, w_pop, w_ud_en, w_fb_en;
  logic [P_NUM_PRED-1:0]   w_drop;
  logic [P_STAT_WIDTH-1:0] r_stat_drop, r_stat_fail, w_drop_cnt, w_fail_cnt;
  logic [P_NUM_PRED-1:0]   w_incr_conf, w_rst_conf, w_incr_use, w_decr_use, w_rst_use, w_load_tag, w_load_value;
  logic [P_NUM_PRED-1:0]   r_incr_conf, r_rst_conf, r_incr_use, r_decr_use, r_rst_use, r_load_tag, r_load_value;

  function automatic logic [P_STAT_WIDTH-1:0] sat_add(input logic [P_STAT_WIDTH-1:0] a,
                                                       input logic [P_STAT_WIDTH-1:0] b);
    logic [P_STAT_WIDTH:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[P_STAT_WIDTH] ? '1 : s[P_STAT_WIDTH-1:0];
  endfunction

  assign w_full     = (r_count == LP_CNT_W'(P_FIFO_DEPTH));
  assign w_empty    = (r_count == '0);
  assign cm_ready_o = rst_i && !w_full;
  assign w_push     = cm_valid_i && cm_ready_o && !flush_i;
  assign w_pop      = !flush_i && !w_empty && ((r_state == S_IDLE) || (r_state == S_UPDATE));

  always_comb begin
    w_push_bnd.act    = cm_lane_valid_i;
    w_push_bnd.index  = cm_index_i;
    w_push_bnd.tag    = cm_tag_i;
    w_push_bnd.hit    = cm_hit_i;
    w_push_bnd.conf   = cm_conf_i;
    w_push_bnd.pred   = cm_pred_value_i;
    w_push_bnd.actual = cm_actual_value_i;
  end

  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_push_bnd;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + LP_PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + LP_PTR_W'(1);
      r_count <= r_count + LP_CNT_W'(w_push) - LP_CNT_W'(w_pop);
    end
  end

  // Lower lane wins an index collision; the head is filtered as it is latched
  always_comb begin
    w_head     = r_mem[r_rd_ptr];
    w_drop     = '0;
    w_drop_cnt = '0;
    for (int i = 1; i < P_NUM_PRED; i++) begin
      for (int j = 0; j < i; j++) begin
        if (w_head.act[i] && w_head.act[j] && (w_head.index[i] == w_head.index[j])) begin
          w_drop[i] = 1'b1;
        end
      end
    end
    for (int i = 0; i < P_NUM_PRED; i++) begin
      w_drop_cnt = w_drop_cnt + P_STAT_WIDTH'(w_drop[i]);
    end
    w_head.act = w_head.act & ~w_drop;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:   if (!w_empty) w_state_nxt = S_LOOKUP;
      S_LOOKUP: w_state_nxt = S_UPDATE;
      S_UPDATE: w_state_nxt = w_empty ? S_IDLE : S_LOOKUP;
      default:  w_state_nxt = S_IDLE;
    endcase
    if (flush_i) w_state_nxt = S_IDLE;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // A miss whose entry still matches the tag is treated as a stale hit that mispredicted
  always_comb begin
    w_incr_conf  = '0;
    w_rst_conf   = '0;
    w_incr_use   = '0;
    w_decr_use   = '0;
    w_rst_use    = '0;
    w_load_tag   = '0;
    w_load_value = '0;
    w_fail_cnt   = '0;
    for (int l = 0; l < P_NUM_PRED; l++) begin
      if (r_work.act[l]) begin
        if (r_work.hit[l] && (r_work.pred[l] == r_work.actual[l])) begin
          w_incr_conf[l] = (r_work.conf[l] != '1);
          w_incr_use[l]  = 1'b1;
        end else if (r_work.hit[l] || (!fb_alloc_avail_i[l] && fb_tag_match_i[l])) begin
          w_rst_conf[l]   = 1'b1;
          w_decr_use[l]   = 1'b1;
          w_load_value[l] = 1'b1;
        end else if (fb_alloc_avail_i[l]) begin
          w_load_tag[l]   = 1'b1;
          w_load_value[l] = 1'b1;
          w_rst_conf[l]   = 1'b1;
          w_rst_use[l]    = 1'b1;
        end else begin
          w_decr_use[l] = 1'b1;
          w_fail_cnt    = w_fail_cnt + P_STAT_WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_work       <= '0;
      r_stat_drop  <= '0;
      r_stat_fail  <= '0;
      r_incr_conf  <= '0;
      r_rst_conf   <= '0;
      r_incr_use   <= '0;
      r_decr_use   <= '0;
      r_rst_use    <= '0;
      r_load_tag   <= '0;
      r_load_value <= '0;
    end else begin
      if (w_pop) begin
        r_work      <= w_head;
        r_stat_drop <= sat_add(r_stat_drop, w_drop_cnt);
      end
      if ((r_state == S_LOOKUP) && !flush_i) begin
        r_incr_conf  <= w_incr_conf;
        r_rst_conf   <= w_rst_conf;
        r_incr_use   <= w_incr_use;
        r_decr_use   <= w_decr_use;
        r_rst_use    <= w_rst_use;
        r_load_tag   <= w_load_tag;
        r_load_value <= w_load_value;
        r_stat_fail  <= sat_add(r_stat_fail, w_fail_cnt);
      end
    end
  end

  assign w_fb_en = (r_state == S_LOOKUP);
  assign w_ud_en = (r_state == S_UPDATE) && !flush_i;

  assign fb_index_o        = w_fb_en ? r_work.index : '0;
  assign fb_tag_o          = w_fb_en ? r_work.tag : '0;
  assign ud_index_o        = w_ud_en ? r_work.index : '0;
  assign ud_tag_o          = w_ud_en ? r_work.tag : '0;
  assign ud_value_o        = w_ud_en ? r_work.actual : '0;
  assign ud_incr_conf_o    = {P_NUM_PRED{w_ud_en}} & r_incr_conf;
  assign ud_rst_conf_o     = {P_NUM_PRED{w_ud_en}} & r_rst_conf;
  assign ud_incr_use_o     = {P_NUM_PRED{w_ud_en}} & r_incr_use;
  assign ud_decr_use_o     = {P_NUM_PRED{w_ud_en}} & r_decr_use;
  assign ud_rst_use_o      = {P_NUM_PRED{w_ud_en}} & r_rst_use;
  assign ud_load_tag_o     = {P_NUM_PRED{w_ud_en}} & r_load_tag;
  assign ud_load_value_o   = {P_NUM_PRED{w_ud_en}} & r_load_value;
  assign busy_o            = (r_state != S_IDLE) || !w_empty;
  assign stat_alloc_fail_o = r_stat_fail;
  assign stat_drop_o       = r_stat_drop;

endmodule

// File: tb/tb_vtage_update_ctrl.sv
// Directed and randomized bench for vtage_update_ctrl against a per-bundle rule model with a table-driven bank.
module tb_vtage_update_ctrl;

  logic            clk_i = 1'b0;
  logic            rst_i;
  logic            cm_valid_i;
  logic            cm_ready_o;
  logic [1:0]      cm_lane_valid_i;
  logic [1:0][7:0] cm_index_i, cm_tag_i, cm_conf_i, cm_pred_value_i, cm_actual_value_i;
  logic [1:0]      cm_hit_i;
  logic            flush_i;
  logic [1:0][7:0] fb_index_o, fb_tag_o;
  logic [1:0]      fb_tag_match_i, fb_alloc_avail_i;
  logic [1:0][7:0] ud_index_o, ud_tag_o, ud_value_o;
  logic [1:0]      ud_incr_conf_o, ud_rst_conf_o, ud_incr_use_o, ud_decr_use_o;
  logic [1:0]      ud_rst_use_o, ud_load_tag_o, ud_load_value_o;
  logic            busy_o;
  logic [15:0]     stat_alloc_fail_o, stat_drop_o;

  vtage_update_ctrl dut (
    .clk_i(clk_i), .rst_i(rst_i), .cm_valid_i(cm_valid_i), .cm_ready_o(cm_ready_o),
    .cm_lane_valid_i(cm_lane_valid_i), .cm_index_i(cm_index_i), .cm_tag_i(cm_tag_i),
    .cm_hit_i(cm_hit_i), .cm_conf_i(cm_conf_i), .cm_pred_value_i(cm_pred_value_i),
    .cm_actual_value_i(cm_actual_value_i), .flush_i(flush_i),
    .fb_index_o(fb_index_o), .fb_tag_o(fb_tag_o), .fb_tag_match_i(fb_tag_match_i),
    .fb_alloc_avail_i(fb_alloc_avail_i), .ud_index_o(ud_index_o),
    .ud_incr_conf_o(ud_incr_conf_o), .ud_rst_conf_o(ud_rst_conf_o),
    .ud_incr_use_o(ud_incr_use_o), .ud_decr_use_o(ud_decr_use_o), .ud_rst_use_o(ud_rst_use_o),
    .ud_load_tag_o(ud_load_tag_o), .ud_load_value_o(ud_load_value_o),
    .ud_tag_o(ud_tag_o), .ud_value_o(ud_value_o), .busy_o(busy_o),
    .stat_alloc_fail_o(stat_alloc_fail_o), .stat_drop_o(stat_drop_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic       v;
    logic [7:0] idx;
    logic [7:0] tag;
    logic       hit;
    logic [7:0] conf;
    logic [7:0] pred;
    logic [7:0] act;
  } lane_t;
  typedef struct packed { lane_t [1:0] ln; } bnd_t;

  // Bank stand-in: per-entry tag-match and free flags, answered combinationally
  bit   bk_match [256];
  bit   bk_avail [256];
  bnd_t bq [$];
  int   total = 0;
  int   bad = 0;
  int   exp_drop = 0;
  int   exp_fail = 0;

  always_comb begin
    for (int l = 0; l < 2; l++) begin
      fb_tag_match_i[l]   = bk_match[fb_index_o[l]];
      fb_alloc_avail_i[l] = bk_avail[fb_index_o[l]];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic lane_t mk(input bit v, input int idx, input int tag, input bit hit,
                               input int conf, input int pred, input int act);
    lane_t r;
    r.v = v; r.idx = 8'(idx); r.tag = 8'(tag); r.hit = hit;
    r.conf = 8'(conf); r.pred = 8'(pred); r.act = 8'(act);
    return r;
  endfunction

  function automatic bit dropped(input bnd_t b, input int l);
    for (int j = 0; j < l; j++)
      if (b.ln[j].v && b.ln[l].v && b.ln[j].idx == b.ln[l].idx) return 1'b1;
    return 1'b0;
  endfunction

  // Expected pulses {incr_conf, rst_conf, incr_use, decr_use, rst_use, load_tag, load_value}
  function automatic logic [6:0] exp_pulses(input bnd_t b, input int l);
    lane_t x = b.ln[l];
    if (!x.v || dropped(b, l)) return 7'b0;
    if (x.hit && x.pred == x.act) return {x.conf != 8'hFF, 6'b010000};
    if (x.hit) return 7'b0101001;
    if (bk_avail[x.idx]) return 7'b0100111;
    if (bk_match[x.idx]) return 7'b0101001;
    return 7'b0001000;
  endfunction

  function automatic logic [6:0] obs_pulses(input int l);
    return {ud_incr_conf_o[l], ud_rst_conf_o[l], ud_incr_use_o[l], ud_decr_use_o[l],
            ud_rst_use_o[l], ud_load_tag_o[l], ud_load_value_o[l]};
  endfunction

  task automatic drive(input bnd_t b);
    for (int l = 0; l < 2; l++) begin
      cm_lane_valid_i[l]   = b.ln[l].v;
      cm_index_i[l]        = b.ln[l].idx;
      cm_tag_i[l]          = b.ln[l].tag;
      cm_hit_i[l]          = b.ln[l].hit;
      cm_conf_i[l]         = b.ln[l].conf;
      cm_pred_value_i[l]   = b.ln[l].pred;
      cm_actual_value_i[l] = b.ln[l].act;
    end
  endtask

  task automatic check_update(input bnd_t b);
    logic [6:0] e;
    for (int l = 0; l < 2; l++) begin
      e = exp_pulses(b, l);
      chk($sformatf("pulses_l%0d", l), 32'(obs_pulses(l)), 32'(e));
      if (e != 7'b0) chk("ud_index", 32'(ud_index_o[l]), 32'(b.ln[l].idx));
      if (e[1]) chk("ud_tag", 32'(ud_tag_o[l]), 32'(b.ln[l].tag));
      if (e[0]) chk("ud_value", 32'(ud_value_o[l]), 32'(b.ln[l].act));
      if (dropped(b, l)) exp_drop++;
      if (e == 7'b0001000) exp_fail++;
    end
    chk("stat_drop", 32'(stat_drop_o), 32'(exp_drop));
    chk("stat_alloc_fail", 32'(stat_alloc_fail_o), 32'(exp_fail));
  endtask

  // Pushes the queued bundles back to back; update k is visible after push edge + 2k + 2
  task automatic run_burst();
    int n = bq.size();
    for (int t = 0; t <= 2 * n + 2; t++) begin
      @(negedge clk_i);
      if (t >= 3 && t % 2 == 1) check_update(bq[(t - 3) / 2]);
      else if (t >= 1) chk("gap_ud", 32'({obs_pulses(1), obs_pulses(0)}), 32'd0);
      if (t >= 2 && t % 2 == 0 && t <= 2 * n) begin
        for (int l = 0; l < 2; l++) begin
          chk("fb_index", 32'(fb_index_o[l]), 32'(bq[(t - 2) / 2].ln[l].idx));
          chk("fb_tag", 32'(fb_tag_o[l]), 32'(bq[(t - 2) / 2].ln[l].tag));
        end
      end
      if (t == 2 * n + 2) chk("busy_end", 32'(busy_o), 32'd0);
      if (t < n) begin
        chk("ready_push", 32'(cm_ready_o), 32'd1);
        drive(bq[t]);
        cm_valid_i = 1'b1;
      end else begin
        cm_valid_i = 1'b0;
      end
    end
    bq.delete();
  endtask

  function automatic bnd_t rand_bnd();
    bnd_t b;
    for (int l = 0; l < 2; l++)
      b.ln[l] = mk(1'($urandom), $urandom_range(0, 7), $urandom_range(0, 255), 1'($urandom),
                   ($urandom_range(0, 3) == 0) ? 255 : $urandom_range(0, 254),
                   $urandom_range(0, 3), $urandom_range(0, 3));
    return b;
  endfunction

  initial begin
    bnd_t b;
    int   pushed;
    rst_i = 1'b0; cm_valid_i = 1'b0; flush_i = 1'b0;
    drive('0);
    #1;
    chk("rst_ready", 32'(cm_ready_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_ud", 32'({obs_pulses(1), obs_pulses(0)}), 32'd0);
    chk("rst_stats", 32'({stat_drop_o, stat_alloc_fail_o}), 32'd0);
    repeat (2) @(negedge clk_i);
    rst_i = 1'b1;
    #1 chk("ready_after_rst", 32'(cm_ready_o), 32'd1);

    // Reset while an update is being issued
    b.ln[0] = mk(1, 5, 1, 1, 3, 7, 7);
    b.ln[1] = mk(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk_i); drive(b); cm_valid_i = 1'b1;
    @(negedge clk_i); cm_valid_i = 1'b0;
    repeat (2) @(negedge clk_i);
    chk("pre_rst_incr_conf", 32'(ud_incr_conf_o[0]), 32'd1);
    rst_i = 1'b0;
    #1;
    chk("midrst_ud", 32'({obs_pulses(1), obs_pulses(0)}), 32'd0);
    chk("midrst_idx", 32'(ud_index_o), 32'd0);
    chk("midrst_busy", 32'(busy_o), 32'd0);
    chk("midrst_ready", 32'(cm_ready_o), 32'd0);
    @(negedge clk_i); rst_i = 1'b1;
    #1;
    chk("rel_ready", 32'(cm_ready_o), 32'd1);
    chk("rel_busy", 32'(busy_o), 32'd0);

    // Directed rule cases
    bq.push_back('{ln: '{mk(0, 0, 0, 0, 0, 0, 0), mk(1, 5, 1, 1, 3, 7, 7)}});
    run_burst();
    bk_avail[9] = 1'b1;
    bq.push_back('{ln: '{mk(1, 9, 8'h11, 0, 0, 1, 8'h2A), mk(0, 0, 0, 0, 0, 0, 0)}});
    run_burst();
    bk_avail[9] = 1'b0;
    bq.push_back('{ln: '{mk(1, 9, 8'h11, 0, 0, 1, 8'h2A), mk(1, 3, 2, 1, 255, 4, 4)}});
    run_burst();
    bq.push_back('{ln: '{mk(1, 12, 3, 1, 5, 6, 6), mk(1, 12, 4, 1, 5, 6, 6)}});
    run_burst();

    // Fill the FIFO faster than it drains, then flush during an UPDATE cycle
    pushed = 0;
    for (int t = 0; t < 12; t++) begin
      @(negedge clk_i);
      if (!cm_ready_o) break;
      b.ln[0] = mk(1, 20 + t, t, 1, t, t, t);
      b.ln[1] = mk(1, 40 + t, t, 1, t, 1, 1);
      drive(b); cm_valid_i = 1'b1;
      pushed++;
    end
    chk("full_pushes", 32'(pushed), 32'd7);
    chk("full_ready", 32'(cm_ready_o), 32'd0);
    chk("full_busy", 32'(busy_o), 32'd1);
    flush_i = 1'b1;
    #1 chk("flush_ud", 32'({obs_pulses(1), obs_pulses(0)}), 32'd0);
    @(negedge clk_i); flush_i = 1'b0; cm_valid_i = 1'b0;
    chk("flush_busy", 32'(busy_o), 32'd0);
    chk("flush_ready", 32'(cm_ready_o), 32'd1);
    for (int t = 0; t < 5; t++) begin
      @(negedge clk_i);
      chk("post_flush_ud", 32'({obs_pulses(1), obs_pulses(0)}), 32'd0);
    end
    chk("flush_stats", 32'({stat_drop_o, stat_alloc_fail_o}), 32'({16'(exp_drop), 16'(exp_fail)}));

    // Randomized bursts with a fresh bank table each time
    for (int r = 0; r < 40; r++) begin
      for (int i = 0; i < 8; i++) begin
        bk_match[i] = 1'($urandom);
        bk_avail[i] = 1'($urandom);
      end
      for (int k = 0, n = $urandom_range(1, 3); k < n; k++) bq.push_back(rand_bnd());
      run_burst();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
